isq_issue_skid: RTL and testbench

- Two-entry registered skid buffer directly downstream of the issue-queue age buffer.
- Accepts the dequeued instruction packet (deq_data/deq_valid/deq_ready) and presents it, registered, to the execute-stage operand read.
- Breaks the combinational path from the oldest-ready select to the FU ready signal.
- Squashes held packets on ROB rollback using the same younger-than robid rule as the queue.

---
 rtl/isq_pkg.sv | 34 +++
 rtl/isq_skid_slot.sv | 44 ++++
 rtl/isq_issue_skid.sv | 119 +++++++++++
 tb/tb_isq_issue_skid.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/isq_pkg.sv
// Shared issue-queue definitions: ROB state encodings, packet field positions,
// and the robid age comparison used by both the age buffer and the skid buffer.
package isq_pkg;

    localparam int ISQ_DATA_WIDTH   = 248;
    localparam int ISQ_ROB_SIZE_LOG = 6;
    localparam int ISQ_ROBID_MSB    = 247;
    localparam int ISQ_ROBID_LSB    = 241;

    typedef enum logic [1:0] {
        ROB_STATE_NORMAL   = 2'd0,
        ROB_STATE_ROLLBACK = 2'd1,
        ROB_STATE_STALL    = 2'd2,
        ROB_STATE_RESERVED = 2'd3
    } rob_state_e;

    // Where a slot's next contents come from.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_S0   = 2'd1,
        SRC_S1   = 2'd2,
        SRC_IN   = 2'd3
    } slot_src_e;

    // Wrap bits differing invert the low-bit ordering; equal robids are not younger.
    function automatic logic is_younger(
        input logic [ISQ_ROB_SIZE_LOG:0] flush_robid,
        input logic [ISQ_ROB_SIZE_LOG:0] robid
    );
        return flush_robid[ISQ_ROB_SIZE_LOG] ^ robid[ISQ_ROB_SIZE_LOG] ^
               (flush_robid[ISQ_ROB_SIZE_LOG-1:0] < robid[ISQ_ROB_SIZE_LOG-1:0]);
    endfunction

endpackage

// File: rtl/isq_skid_slot.sv
// One skid-buffer entry: valid bit plus packet data, with clear, shift-in and load.
module isq_skid_slot
    import isq_pkg::*;
#(
    parameter int DATA_WIDTH = ISQ_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_shift_data,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // Entry register; clear wins so an empty slot always holds zero data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_WIDTH{1'b0}};
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_WIDTH{1'b0}};
        end else if (i_shift) begin
            r_valid <= 1'b1;
            r_data  <= i_shift_data;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/isq_issue_skid.sv
// Two-entry registered skid buffer between the issue-queue select and execute,
// squashing held or incoming packets younger than a rollback flush robid.
module isq_issue_skid
    import isq_pkg::*;
#(
    parameter int DATA_WIDTH   = ISQ_DATA_WIDTH,
    parameter int ROB_SIZE_LOG = ISQ_ROB_SIZE_LOG,
    parameter int ROBID_MSB    = ISQ_ROBID_MSB,
    parameter int ROBID_LSB    = ISQ_ROBID_LSB
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic [1:0]              rob_state,
    input  logic                    flush_valid,
    input  logic [ROB_SIZE_LOG:0]   flush_robid,
    output logic [1:0]              occupancy
);

    logic                  w_v0;
    logic                  w_v1;
    logic [DATA_WIDTH-1:0] w_d0;
    logic [DATA_WIDTH-1:0] w_d1;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_kill_en;
    logic                  w_kill_s0;
    logic                  w_kill_s1;
    logic                  w_kill_in;
    slot_src_e             w_a0;
    slot_src_e             w_a1;
    slot_src_e             w_n0;
    slot_src_e             w_n1;

    function automatic logic survives(
        input slot_src_e src,
        input logic      kill_s0,
        input logic      kill_s1,
        input logic      kill_in
    );
        case (src)
            SRC_S0:  return !kill_s0;
            SRC_S1:  return !kill_s1;
            SRC_IN:  return !kill_in;
            default: return 1'b0;
        endcase
    endfunction

    assign w_pop     = w_v0 && out_ready;
    assign w_push    = in_valid && !w_v1;
    assign w_kill_en = flush_valid && (rob_state == ROB_STATE_ROLLBACK);
    assign w_kill_s0 = w_kill_en && is_younger(flush_robid, w_d0[ROBID_MSB:ROBID_LSB]);
    assign w_kill_s1 = w_kill_en && is_younger(flush_robid, w_d1[ROBID_MSB:ROBID_LSB]);
    assign w_kill_in = w_kill_en && is_younger(flush_robid, in_data[ROBID_MSB:ROBID_LSB]);

    // Next-slot sources: pop shifts, push fills lowest free, kill drops then compacts.
    always_comb begin
        w_a0 = w_v0 ? SRC_S0 : SRC_NONE;
        w_a1 = w_v1 ? SRC_S1 : SRC_NONE;
        if (w_pop) begin
            w_a0 = w_a1;
            w_a1 = SRC_NONE;
        end else begin
            w_a1 = w_a1;
        end
        if (w_push) begin
            if (w_a0 == SRC_NONE) begin
                w_a0 = SRC_IN;
            end else begin
                w_a1 = SRC_IN;
            end
        end else begin
            w_a0 = w_a0;
        end
        if (survives(w_a0, w_kill_s0, w_kill_s1, w_kill_in)) begin
            w_n0 = w_a0;
            w_n1 = survives(w_a1, w_kill_s0, w_kill_s1, w_kill_in) ? w_a1 : SRC_NONE;
        end else begin
            w_n0 = survives(w_a1, w_kill_s0, w_kill_s1, w_kill_in) ? w_a1 : SRC_NONE;
            w_n1 = SRC_NONE;
        end
    end

    isq_skid_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear      (w_n0 == SRC_NONE),
        .i_shift      (w_n0 == SRC_S1),
        .i_shift_data (w_d1),
        .i_load       (w_n0 == SRC_IN),
        .i_load_data  (in_data),
        .o_valid      (w_v0),
        .o_data       (w_d0)
    );

    // The tail never receives the head, so its shift path is unused.
    isq_skid_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear      (w_n1 == SRC_NONE),
        .i_shift      (1'b0),
        .i_shift_data ({DATA_WIDTH{1'b0}}),
        .i_load       (w_n1 == SRC_IN),
        .i_load_data  (in_data),
        .o_valid      (w_v1),
        .o_data       (w_d1)
    );

    assign in_ready  = !w_v1;
    assign out_valid = w_v0;
    assign out_data  = {DATA_WIDTH{w_v0}} & w_d0;
    assign occupancy = {1'b0, w_v0} + {1'b0, w_v1};

endmodule

// File: tb/tb_isq_issue_skid.sv
// Directed bench for isq_issue_skid: handshake, streaming, rollback kill patterns,
// robid wrap handling and asynchronous reset.
module tb_isq_issue_skid;
    import isq_pkg::*;

    localparam int DW = ISQ_DATA_WIDTH;

    logic          clock;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    rob_state;
    logic          flush_valid;
    logic [6:0]    flush_robid;
    logic [1:0]    occupancy;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    isq_issue_skid dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rob_state   (rob_state),
        .flush_valid (flush_valid),
        .flush_robid (flush_robid),
        .occupancy   (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mk(input logic [6:0] robid, input logic [31:0] payload);
        logic [DW-1:0] p;
        p = {DW{1'b0}};
        p[ISQ_ROBID_MSB:ISQ_ROBID_LSB] = robid;
        p[31:0] = payload;
        return p;
    endfunction

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] p);
        in_data  = p;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic rollback(input logic [6:0] rid);
        rob_state   = ROB_STATE_ROLLBACK;
        flush_valid = 1'b1;
        flush_robid = rid;
        step();
        flush_valid = 1'b0;
        rob_state   = ROB_STATE_NORMAL;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        check_val("drain_occ", 256'(occupancy), 256'(2'd0));
    endtask

    initial begin
        reset_n     = 1'b0;
        in_data     = {DW{1'b0}};
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        rob_state   = ROB_STATE_NORMAL;
        flush_valid = 1'b0;
        flush_robid = 7'h00;
        #12;
        check_val("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check_val("rst_out_data", 256'(out_data), 256'(0));
        check_val("rst_occ", 256'(occupancy), 256'(2'd0));
        check_val("rst_in_ready", 256'(in_ready), 256'(1'b1));
        #5 reset_n = 1'b1;
        step();

        // Single push then second push with execute stalled.
        push(mk(7'h05, 32'hA1));
        check_val("p1_out_valid", 256'(out_valid), 256'(1'b1));
        check_val("p1_occ", 256'(occupancy), 256'(2'd1));
        check_val("p1_in_ready", 256'(in_ready), 256'(1'b1));
        check_val("p1_data", 256'(out_data), 256'(mk(7'h05, 32'hA1)));
        push(mk(7'h06, 32'hA2));
        check_val("p2_occ", 256'(occupancy), 256'(2'd2));
        check_val("p2_in_ready", 256'(in_ready), 256'(1'b0));
        check_val("p2_head", 256'(out_data), 256'(mk(7'h05, 32'hA1)));
        out_ready = 1'b1;
        step();
        check_val("pop_tail_to_head", 256'(out_data), 256'(mk(7'h06, 32'hA2)));
        check_val("pop_occ", 256'(occupancy), 256'(2'd1));
        step();
        out_ready = 1'b0;
        check_val("empty_valid", 256'(out_valid), 256'(1'b0));

        // Streaming with execute always ready: no bubbles, strict order.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data  = mk(7'(i), 32'hB0 + 32'(i));
            in_valid = 1'b1;
            step();
            check_val("stream_valid", 256'(out_valid), 256'(1'b1));
            check_val("stream_data", 256'(out_data), 256'(mk(7'(i), 32'hB0 + 32'(i))));
            check_val("stream_occ", 256'(occupancy), 256'(2'd1));
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check_val("stream_end_occ", 256'(occupancy), 256'(2'd0));

        // Full, pop and offered push: no push while full, drops to one entry.
        push(mk(7'h01, 32'hC1));
        push(mk(7'h02, 32'hC2));
        out_ready = 1'b1;
        in_data   = mk(7'h03, 32'hC3);
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("full_pop_occ", 256'(occupancy), 256'(2'd1));
        check_val("full_pop_data", 256'(out_data), 256'(mk(7'h02, 32'hC2)));
        drain();

        // Flush strobe outside rollback state kills nothing.
        push(mk(7'h30, 32'hD0));
        flush_valid = 1'b1;
        flush_robid = 7'h00;
        step();
        flush_valid = 1'b0;
        check_val("norm_flush_occ", 256'(occupancy), 256'(2'd1));
        drain();

        // Tail younger than flush point: tail killed, head kept.
        push(mk(7'h03, 32'hE1));
        push(mk(7'h10, 32'hE2));
        rollback(7'h08);
        check_val("kill_tail_occ", 256'(occupancy), 256'(2'd1));
        check_val("kill_tail_head", 256'(out_data), 256'(mk(7'h03, 32'hE1)));
        check_val("kill_tail_ready", 256'(in_ready), 256'(1'b1));
        drain();

        // Head younger: head killed, tail compacts into the head slot.
        push(mk(7'h12, 32'hF1));
        push(mk(7'h02, 32'hF2));
        rollback(7'h05);
        check_val("kill_head_occ", 256'(occupancy), 256'(2'd1));
        check_val("kill_head_data", 256'(out_data), 256'(mk(7'h02, 32'hF2)));
        drain();

        // Robid wrap: 41 is younger than 3E; equal robid survives.
        push(mk(7'h41, 32'h11));
        rollback(7'h3E);
        check_val("wrap_kill_valid", 256'(out_valid), 256'(1'b0));
        check_val("wrap_kill_occ", 256'(occupancy), 256'(2'd0));
        push(mk(7'h41, 32'h12));
        rollback(7'h41);
        check_val("equal_keep_valid", 256'(out_valid), 256'(1'b1));
        check_val("equal_keep_data", 256'(out_data), 256'(mk(7'h41, 32'h12)));
        drain();

        // Incoming packet killed in its push cycle.
        in_data     = mk(7'h20, 32'h21);
        in_valid    = 1'b1;
        rob_state   = ROB_STATE_ROLLBACK;
        flush_valid = 1'b1;
        flush_robid = 7'h10;
        check_val("inkill_in_ready", 256'(in_ready), 256'(1'b1));
        step();
        in_valid    = 1'b0;
        flush_valid = 1'b0;
        rob_state   = ROB_STATE_NORMAL;
        check_val("inkill_valid", 256'(out_valid), 256'(1'b0));
        check_val("inkill_occ", 256'(occupancy), 256'(2'd0));

        // Asynchronous reset mid-handshake while full.
        push(mk(7'h07, 32'h31));
        push(mk(7'h08, 32'h32));
        in_data   = mk(7'h09, 32'h33);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_valid", 256'(out_valid), 256'(1'b0));
        check_val("arst_occ", 256'(occupancy), 256'(2'd0));
        check_val("arst_data", 256'(out_data), 256'(0));
        check_val("arst_in_ready", 256'(in_ready), 256'(1'b1));
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
